// File: rtl/display_formatter.sv
// display_formatter: sequential binary-to-BCD converter for the six-digit
// seven-segment display. One shift-and-add-3 step per clock, then a single
// FINISH edge writes digits, blanking, decimal points and overflow together
// so the display never shows a partially converted value.
module display_formatter #(
  parameter int IN_WIDTH = 20
) (
  input  logic                clock,
  input  logic                reset_L,
  input  logic                load,
  input  logic [IN_WIDTH-1:0] value,
  input  logic                lz_en,
  input  logic [5:0]          dp_sel,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic [3:0]          Num_Hex0,
  output logic [3:0]          Num_Hex1,
  output logic [3:0]          Num_Hex2,
  output logic [3:0]          Num_Hex3,
  output logic [4:0]          Num_Hex4,
  output logic [4:0]          Num_Hex5,
  output logic [5:0]          Blanked,
  output logic [5:0]          DP_out
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] CONV   = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  // Counter value seen on the edge that performs the final shift.
  localparam logic [4:0] LAST_SHIFT = 5'(IN_WIDTH - 1);

  logic [1:0]          state_r;
  logic [IN_WIDTH-1:0] bin_r;
  logic [23:0]         bcd_r;
  logic [4:0]          cnt_r;
  logic                lz_r;
  logic [5:0]          dp_r;
  logic                ovf_r;

  logic [23:0]         bcd_adj_s;
  logic [23:0]         fin_digits_s;
  logic [5:0]          blank_s;
  logic                zero_run_s;
  logic                too_big_s;

  // Add 3 to every BCD nibble that is 5 or more, ahead of the left shift.
  function automatic logic [23:0] add3_all(input logic [23:0] b);
    logic [23:0] r;
    r = b;
    for (int i = 0; i < 6; i++) begin
      if (r[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = r[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = r[4*i +: 4];
      end
    end
    return r;
  endfunction

  // Values above 999999 cannot be shown on six digits.
  always_comb begin
    too_big_s = (32'(value) > 32'd999999);
  end

  // Per-nibble correction for the current conversion step.
  always_comb begin
    bcd_adj_s = add3_all(bcd_r);
  end

  // Final digits: saturate to all nines on overflow.
  always_comb begin
    if (ovf_r) begin
      fin_digits_s = 24'h999999;
    end else begin
      fin_digits_s = bcd_r;
    end
  end

  // Leading-zero blanking: digit i (i>=1) dark when it and all higher digits are zero.
  always_comb begin
    blank_s    = 6'b000000;
    zero_run_s = 1'b1;
    for (int i = 5; i >= 1; i--) begin
      zero_run_s = zero_run_s & (fin_digits_s[4*i +: 4] == 4'd0);
      blank_s[i] = lz_r & zero_run_s;
    end
  end

  // Conversion FSM and datapath: capture, shift-and-add-3, hand-off.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state_r <= IDLE;
      bin_r   <= '0;
      bcd_r   <= 24'h000000;
      cnt_r   <= 5'd0;
      lz_r    <= 1'b0;
      dp_r    <= 6'b000000;
      ovf_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (load) begin
            bin_r   <= value;
            lz_r    <= lz_en;
            dp_r    <= dp_sel;
            ovf_r   <= too_big_s;
            bcd_r   <= 24'h000000;
            cnt_r   <= 5'd0;
            state_r <= CONV;
          end else begin
            state_r <= IDLE;
          end
        end
        CONV: begin
          bcd_r <= {bcd_adj_s[22:0], bin_r[IN_WIDTH-1]};
          bin_r <= bin_r << 1;
          cnt_r <= cnt_r + 5'd1;
          if (cnt_r == LAST_SHIFT) begin
            state_r <= FINISH;
          end else begin
            state_r <= CONV;
          end
        end
        FINISH: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Registered display outputs and handshake, updated only on the FINISH edge.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      Num_Hex0 <= 4'd0;
      Num_Hex1 <= 4'd0;
      Num_Hex2 <= 4'd0;
      Num_Hex3 <= 4'd0;
      Num_Hex4 <= 5'd0;
      Num_Hex5 <= 5'd0;
      Blanked  <= 6'b111111;
      DP_out   <= 6'b000000;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (load) begin
            busy <= 1'b1;
          end else begin
            busy <= busy;
          end
        end
        FINISH: begin
          busy     <= 1'b0;
          done     <= 1'b1;
          overflow <= ovf_r;
          Num_Hex0 <= fin_digits_s[3:0];
          Num_Hex1 <= fin_digits_s[7:4];
          Num_Hex2 <= fin_digits_s[11:8];
          Num_Hex3 <= fin_digits_s[15:12];
          Num_Hex4 <= {1'b0, fin_digits_s[19:16]};
          Num_Hex5 <= {1'b0, fin_digits_s[23:20]};
          Blanked  <= blank_s;
          DP_out   <= dp_r;
        end
        default: begin
          busy <= busy;
        end
      endcase
    end
  end

endmodule
